mem_seq: RTL and testbench
==========================

MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory word-address width (1024 words).
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have parameter LEN_W, default 4, burst-length field width (bursts of 1..16 words).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  requester presents a request.
REQ-007 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  start word address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data (write requests only).
REQ-011 SHALL have port req_len  input  LEN_W  read burst length minus one.
REQ-012 SHALL have port mem_wr_en  output  1  write enable to the downstream dual-port memory.
REQ-013 SHALL have port mem_rd_en  output  1  read enable to the memory.
REQ-014 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-015 SHALL have port mem_data_in  output  DATA_W  memory write data.
REQ-016 SHALL have port mem_data_out  input  DATA_W  memory registered read data (valid one cycle after mem_rd_en).
REQ-017 SHALL have port rsp_valid  output  1  rsp_data holds a read word.
REQ-018 SHALL have port rsp_data  output  DATA_W  read word.
REQ-019 SHALL have port rsp_last  output  1  final word of a read burst.
REQ-020 SHALL have port busy  output  1  state not IDLE or a response still in flight.

Function
REQ-021 SHALL implement FSM states IDLE, WRITE, READ; req_ready = (state == IDLE); handshake completes on the rising edge where req_valid && req_ready.
REQ-022 IDLE, accepted write: next edge registers mem_wr_en=1, mem_addr=req_addr, mem_data_in=req_wdata and moves to WRITE; WRITE lasts exactly one cycle, then mem_wr_en=0 and the FSM returns to IDLE.
REQ-023 IDLE, accepted read: next edge registers mem_rd_en=1, mem_addr=req_addr, loads beat counter with the effective length, and moves to READ.
REQ-024 READ: mem_rd_en held 1 for exactly (effective length + 1) consecutive cycles; mem_addr increments by 1 each cycle, wrapping from 2^ADDR_W-1 to 0; after the final beat, mem_rd_en=0 and FSM goes to IDLE.
REQ-025 mem_wr_en and mem_rd_en SHALL never both be 1.
REQ-026 rsp_valid SHALL be mem_rd_en delayed by one cycle; rsp_data SHALL pass mem_data_out through combinationally; rsp_last SHALL be the final-beat flag delayed by one cycle.
REQ-027 Read latency: first rsp_valid in the 2nd cycle after the acceptance edge; one word per cycle thereafter, no gaps.
REQ-028 Responses have no backpressure; the consumer SHALL accept every rsp_valid word.
REQ-029 busy = (state != IDLE) || rsp_valid.
REQ-030 Requests are served strictly in order; maximum throughput is one write per 2 cycles.

Reset
REQ-031 While reset is low: state=IDLE, mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_data_in=0, rsp_valid=0, rsp_last=0, counter=0; req_ready=1 and busy=0 immediately.
REQ-032 Reset asserted mid-burst SHALL abort the burst; no rsp_valid is produced for in-flight beats after reset asserts.

Configuration
REQ-033 Macro MEM_SEQ_BURST_EN defined: effective read length = req_len + 1 words.
REQ-034 Macro MEM_SEQ_BURST_EN undefined: req_len ignored, every read is single-word with rsp_last=1, and the beat counter is not instantiated.

Verification
REQ-035 Write addr=0x005, wdata=0xBEEF, then read addr=0x005 len=0 -> mem_wr_en one cycle, rsp_valid one cycle with rsp_data=0xBEEF and rsp_last=1, two cycles after read acceptance.
REQ-036 (BURST_EN) Read addr=0x3FE, len=3 -> mem_addr 0x3FE, 0x3FF, 0x000, 0x001; four back-to-back rsp_valid; rsp_last only on the 4th.
REQ-037 req_valid held high with back-to-back writes -> req_ready deasserted during every WRITE cycle; one write per 2 cycles; no request lost or duplicated.
REQ-038 Reset driven low during beat 2 of a len=7 burst -> all outputs to reset values in the same cycle; no further rsp_valid; req_ready=1.
REQ-039 (BURST_EN undefined) Read with len=5 -> exactly one mem_rd_en cycle and one response with rsp_last=1.
REQ-040 Random mixed traffic against a reference memory model -> every response matches the model, and mem_wr_en and mem_rd_en are never high together.

Source files
------------

// File: rtl/mem_seq.sv
// mem_seq: request sequencer in front of a dual-port memory with registered read data.
//   Accepts single-word writes and (optionally burst) reads from a valid/ready
//   requester, drives the memory write/read port, and streams read words back
//   with no backpressure.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req_valid    request present           req_ready  block idle, can accept
//   req_we       1 = write, 0 = read       req_addr   start word address
//   req_wdata    write data                req_len    read burst length minus one
//   mem_wr_en    memory write enable       mem_rd_en  memory read enable
//   mem_addr     memory address            mem_data_in memory write data
//   mem_data_out memory read data (one cycle after mem_rd_en)
//   rsp_valid    read word valid           rsp_data   read word
//   rsp_last     final word of a burst     busy       work or response in flight
// Configuration:
//   MEM_SEQ_BURST_EN defined   -> reads return req_len + 1 consecutive words
//   MEM_SEQ_BURST_EN undefined -> req_len ignored, every read is one word
module mem_seq #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t            r_state, w_state_nx;
  logic              r_wr_en, w_wr_en_nx;
  logic              r_rd_en, w_rd_en_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [DATA_W-1:0] r_wdata, w_wdata_nx;
  logic              r_rsp_valid, r_rsp_last;
  logic              w_last;
`ifdef MEM_SEQ_BURST_EN
  // Beats remaining after the current one; the beat with zero left is the last.
  logic [LEN_W-1:0]  r_cnt, w_cnt_nx;
  assign w_last = (r_state == READ) && (r_cnt == '0);
`else
  logic              w_unused_len;
  assign w_unused_len = ^req_len;
  assign w_last = (r_state == READ);
`endif
  always_comb begin
    w_state_nx = r_state;
    w_wr_en_nx = 1'b0;
    w_rd_en_nx = 1'b0;
    w_addr_nx  = r_addr;
    w_wdata_nx = r_wdata;
`ifdef MEM_SEQ_BURST_EN
    w_cnt_nx   = r_cnt;
`endif
    case (r_state)
      IDLE: if (req_valid) begin
        w_addr_nx = req_addr;
        if (req_we) begin
          w_state_nx = WRITE;
          w_wr_en_nx = 1'b1;
          w_wdata_nx = req_wdata;
        end else begin
          w_state_nx = READ;
          w_rd_en_nx = 1'b1;
`ifdef MEM_SEQ_BURST_EN
          w_cnt_nx   = req_len;
`endif
        end
      end
      WRITE: w_state_nx = IDLE;
      READ: if (w_last) begin
        w_state_nx = IDLE;
      end else begin
        w_rd_en_nx = 1'b1;
        w_addr_nx  = r_addr + 1'b1;
`ifdef MEM_SEQ_BURST_EN
        w_cnt_nx   = r_cnt - 1'b1;
`endif
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_wr_en     <= w_wr_en_nx;
      r_rd_en     <= w_rd_en_nx;
      r_addr      <= w_addr_nx;
      r_wdata     <= w_wdata_nx;
      r_rsp_valid <= r_rd_en;
      r_rsp_last  <= w_last;
    end
  end
`ifdef MEM_SEQ_BURST_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else r_cnt <= w_cnt_nx;
  end
`endif
  assign req_ready   = (r_state == IDLE);
  assign mem_wr_en   = r_wr_en;
  assign mem_rd_en   = r_rd_en;
  assign mem_addr    = r_addr;
  assign mem_data_in = r_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = mem_data_out;
  assign rsp_last    = r_rsp_last;
  assign busy        = (r_state != IDLE) || r_rsp_valid;
endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: directed table-driven bench for mem_seq with a behavioural memory.
module tb_mem_seq;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LW = 4;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [LW-1:0] req_len = '0;
  logic          req_ready, mem_wr_en, mem_rd_en, rsp_valid, rsp_last, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, rsp_data;
  logic [DW-1:0] mem_data_out = '0;
  mem_seq #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {6'h0, a} ^ 16'h5A00;
  endfunction
  function automatic int beats_of(input logic [LW-1:0] len);
`ifdef MEM_SEQ_BURST_EN
    return int'(len) + 1;
`else
    return 1;
`endif
  endfunction
  logic [DW-1:0] mem [1024];
  logic          mem_written [1024] = '{default: 1'b0};
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_data_in;
      mem_written[mem_addr] <= 1'b1;
    end
    if (mem_rd_en) mem_data_out <= mem_written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
  end
  int wr_cycles = 0, rd_cycles = 0, both_hi = 0;
  always @(negedge clk) begin
    if (mem_wr_en) wr_cycles++;
    if (mem_rd_en) rd_cycles++;
    if (mem_wr_en && mem_rd_en) both_hi++;
  end
  logic [DW-1:0] ref_mem [1024];
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LW-1:0] l);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_len = l;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    issue(1'b1, a, d, '0);
    chk("wr_en", 32'(mem_wr_en), 1);
    chk("wr_rd_en", 32'(mem_rd_en), 0);
    chk("wr_addr", 32'(mem_addr), 32'(a));
    chk("wr_data", 32'(mem_data_in), 32'(d));
    chk("wr_ready", 32'(req_ready), 0);
    chk("wr_busy", 32'(busy), 1);
    ref_mem[a] = d;
    @(negedge clk);
    chk("wr_en_drop", 32'(mem_wr_en), 0);
    chk("wr_ready_back", 32'(req_ready), 1);
  endtask
  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [DW-1:0] exp0);
    int nb = beats_of(l);
    int rd0 = rd_cycles;
    logic [AW-1:0] ak;
    issue(1'b0, a, '0, l);
    chk("rd_en", 32'(mem_rd_en), 1);
    chk("rd_addr0", 32'(mem_addr), 32'(a));
    chk("rd_no_rsp_yet", 32'(rsp_valid), 0);
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      ak = a + AW'(k);
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_data", 32'(rsp_data), 32'(k == 0 ? exp0 : ref_mem[ak]));
      chk("rsp_last", 32'(rsp_last), 32'(k == nb - 1));
      if (k < nb - 1) begin
        chk("rd_en_beat", 32'(mem_rd_en), 1);
        chk("rd_addr_beat", 32'(mem_addr), 32'(AW'(ak + 1'b1)));
      end else begin
        chk("rd_en_done", 32'(mem_rd_en), 0);
        chk("rd_ready_done", 32'(req_ready), 1);
      end
    end
    @(negedge clk);
    chk("rsp_done", 32'(rsp_valid), 0);
    chk("busy_done", 32'(busy), 0);
    chk("rd_cycle_count", 32'(rd_cycles - rd0), 32'(nb));
  endtask
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [LW-1:0] len;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl [12];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int wr0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(AW'(i));
    tbl[0]  = '{1'b1, 10'h005, 16'hBEEF, 4'd0, 16'h0000};
    tbl[1]  = '{1'b0, 10'h005, 16'h0000, 4'd0, 16'hBEEF};
    tbl[2]  = '{1'b1, 10'h3FF, 16'h1234, 4'd0, 16'h0000};
    tbl[3]  = '{1'b1, 10'h000, 16'hABCD, 4'd0, 16'h0000};
    tbl[4]  = '{1'b0, 10'h3FF, 16'h0000, 4'd1, 16'h1234};
    tbl[5]  = '{1'b1, 10'h005, 16'hCAFE, 4'd0, 16'h0000};
    tbl[6]  = '{1'b0, 10'h005, 16'h0000, 4'd0, 16'hCAFE};
    tbl[7]  = '{1'b1, 10'h200, 16'h0F0F, 4'd0, 16'h0000};
    tbl[8]  = '{1'b0, 10'h200, 16'h0000, 4'd5, 16'h0F0F};
    tbl[9]  = '{1'b1, 10'h3FE, 16'h1111, 4'd0, 16'h0000};
    tbl[10] = '{1'b1, 10'h001, 16'h2222, 4'd0, 16'h0000};
    tbl[11] = '{1'b0, 10'h3FE, 16'h0000, 4'd3, 16'h1111};
    #1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].we) do_write(tbl[i].addr, tbl[i].wdata);
      else do_read(tbl[i].addr, tbl[i].len, tbl[i].exp);
    end
    wr0 = wr_cycles;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(10'h100 + i); req_wdata = DW'(16'h7700 + i);
      @(negedge clk);
      chk("b2b_wr_en", 32'(mem_wr_en), 1);
      chk("b2b_addr", 32'(mem_addr), 32'(10'h100 + i));
      chk("b2b_data", 32'(mem_data_in), 32'(16'h7700 + i));
      chk("b2b_ready_low", 32'(req_ready), 0);
      ref_mem[10'h100 + i] = DW'(16'h7700 + i);
      @(negedge clk);
      chk("b2b_wr_idle", 32'(mem_wr_en), 0);
      chk("b2b_ready_high", 32'(req_ready), 1);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_write_count", 32'(wr_cycles - wr0), 4);
    do_read(10'h101, 4'd0, 16'h7701);
    do_read(10'h103, 4'd0, 16'h7703);
    issue(1'b0, 10'h080, '0, 4'd7);
    chk("abort_rd_en", 32'(mem_rd_en), 1);
`ifdef MEM_SEQ_BURST_EN
    @(negedge clk);
`endif
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_wr_en", 32'(mem_wr_en), 0);
    chk("abort_rd_en_clr", 32'(mem_rd_en), 0);
    chk("abort_addr", 32'(mem_addr), 0);
    chk("abort_data_in", 32'(mem_data_in), 0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_rsp_last", 32'(rsp_last), 0);
    chk("abort_ready", 32'(req_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 0);
      chk("abort_no_rd", 32'(mem_rd_en), 0);
    end
    do_read(10'h005, 4'd0, 16'hCAFE);
    chk("never_both_enables", 32'(both_hi), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
